// File: rtl/reg_bank_pipe_pkg.sv
// rtl/reg_bank_pipe_pkg.sv - shared defaults for the reg_bank_pipe slice
// Purpose: default geometry of the register bank.
// Ports: none (package).
// Config macro: REG_BANK_PARITY_EN (consumed by the interface, stage and top).
package reg_bank_pipe_pkg;

  localparam int DEF_NUM_CH = 3;
  localparam int DEF_WIDTH  = 8;
  localparam int DEF_DEPTH  = 2;

endpackage

// File: rtl/reg_bank_pipe_if.sv
// rtl/reg_bank_pipe_if.sv - handshake/data bundle between producer and reg_bank_pipe
// Purpose: groups the control, data and status signals of the register bank.
// Ports (signals): enable, flush, in_valid, ch_en[NUM_CH], d[NUM_CH*WIDTH] from the producer;
//   q[NUM_CH*WIDTH], out_valid [, q_par[NUM_CH]] from the bank.
// Config macro: REG_BANK_PARITY_EN adds q_par.
interface reg_bank_pipe_if
  import reg_bank_pipe_pkg::*;
#(
  parameter int NUM_CH = DEF_NUM_CH,
  parameter int WIDTH  = DEF_WIDTH
);

  logic                    enable;
  logic                    flush;
  logic                    in_valid;
  logic [NUM_CH-1:0]       ch_en;
  logic [NUM_CH*WIDTH-1:0] d;
  logic [NUM_CH*WIDTH-1:0] q;
  logic                    out_valid;

`ifdef REG_BANK_PARITY_EN
  logic [NUM_CH-1:0]       q_par;

  modport master (output enable, flush, in_valid, ch_en, d,
                  input  q, out_valid, q_par);
  modport slave  (input  enable, flush, in_valid, ch_en, d,
                  output q, out_valid, q_par);
`else
  modport master (output enable, flush, in_valid, ch_en, d,
                  input  q, out_valid);
  modport slave  (input  enable, flush, in_valid, ch_en, d,
                  output q, out_valid);
`endif

endinterface

// File: rtl/reg_bank_stage.sv
// rtl/reg_bank_stage.sv - one pipeline stage of the register bank
// Purpose: holds NUM_CH lanes of WIDTH bits plus a valid bit (and per-lane parity).
// Ports: clk, rst_n (sync, active-low); load (advance), flush (clear valid);
//   vld_in, mask[NUM_CH] (lanes to capture), data_in -> data_out, vld_out;
//   par_in/par_out per lane when parity is built in.
// Config macro: REG_BANK_PARITY_EN adds the parity registers.
module reg_bank_stage
  import reg_bank_pipe_pkg::*;
#(
  parameter int NUM_CH = DEF_NUM_CH,
  parameter int WIDTH  = DEF_WIDTH
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    load,
  input  logic                    flush,
  input  logic                    vld_in,
  input  logic [NUM_CH-1:0]       mask,
  input  logic [NUM_CH*WIDTH-1:0] data_in,
`ifdef REG_BANK_PARITY_EN
  input  logic [NUM_CH-1:0]       par_in,
  output logic [NUM_CH-1:0]       par_out,
`endif
  output logic [NUM_CH*WIDTH-1:0] data_out,
  output logic                    vld_out
);

  logic [NUM_CH*WIDTH-1:0] data_q, data_d;
  logic                    vld_q, vld_d;
`ifdef REG_BANK_PARITY_EN
  logic [NUM_CH-1:0]       par_q, par_d;
`endif

  // Flush only kills the valid bit; data is left in place.
  always_comb begin
    data_d = data_q;
    vld_d  = vld_q;
`ifdef REG_BANK_PARITY_EN
    par_d  = par_q;
`endif
    if (flush) begin
      vld_d = 1'b0;
    end else if (load) begin
      vld_d = vld_in;
      for (int i = 0; i < NUM_CH; i++) begin
        if (mask[i]) begin
          data_d[i*WIDTH +: WIDTH] = data_in[i*WIDTH +: WIDTH];
`ifdef REG_BANK_PARITY_EN
          par_d[i] = par_in[i];
`endif
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      data_q <= '0;
      vld_q  <= 1'b0;
`ifdef REG_BANK_PARITY_EN
      par_q  <= '0;
`endif
    end else begin
      data_q <= data_d;
      vld_q  <= vld_d;
`ifdef REG_BANK_PARITY_EN
      par_q  <= par_d;
`endif
    end
  end

  assign data_out = data_q;
  assign vld_out  = vld_q;
`ifdef REG_BANK_PARITY_EN
  assign par_out  = par_q;
`endif

endmodule

// File: rtl/reg_bank_pipe.sv
// rtl/reg_bank_pipe.sv - parametrised multi-lane retiming register bank
// Purpose: NUM_CH lanes of WIDTH bits through DEPTH registered stages with per-stage valid,
//   per-lane load mask on stage 0, global stall and synchronous flush.
// Ports: clk, rst_n (sync, active-low); bus (reg_bank_pipe_if.slave): enable, flush,
//   in_valid, ch_en, d in; q, out_valid [, q_par] out, all straight from the last stage.
// Config macro: REG_BANK_PARITY_EN enables per-lane even parity carried with the data.
module reg_bank_pipe
  import reg_bank_pipe_pkg::*;
#(
  parameter int NUM_CH = DEF_NUM_CH,
  parameter int WIDTH  = DEF_WIDTH,
  parameter int DEPTH  = DEF_DEPTH
) (
  input logic             clk,
  input logic             rst_n,
  reg_bank_pipe_if.slave  bus
);

  localparam int NW = NUM_CH * WIDTH;

  // Index k is the input of stage k; index DEPTH is the last stage's output.
  logic [NW-1:0]     stg_data [DEPTH+1];
  logic [DEPTH:0]    stg_vld;
  logic [NUM_CH-1:0] first_mask;

  assign stg_data[0] = bus.d;
  assign stg_vld[0]  = bus.in_valid;
  // A bubble must not overwrite stage 0, so in_valid gates the lane mask.
  assign first_mask  = bus.in_valid ? bus.ch_en : '0;

`ifdef REG_BANK_PARITY_EN
  logic [NUM_CH-1:0] stg_par [DEPTH+1];
  logic [NUM_CH-1:0] d_par;

  always_comb begin
    d_par = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      d_par[i] = ^bus.d[i*WIDTH +: WIDTH];
    end
  end

  assign stg_par[0] = d_par;
  assign bus.q_par  = stg_par[DEPTH];
`endif

  for (genvar k = 0; k < DEPTH; k++) begin : g_stage
    reg_bank_stage #(
      .NUM_CH (NUM_CH),
      .WIDTH  (WIDTH)
    ) u_stage (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (bus.enable),
      .flush    (bus.flush),
      .vld_in   (stg_vld[k]),
      // Later stages always take the whole word.
      .mask     ((k == 0) ? first_mask : {NUM_CH{1'b1}}),
      .data_in  (stg_data[k]),
`ifdef REG_BANK_PARITY_EN
      .par_in   (stg_par[k]),
      .par_out  (stg_par[k+1]),
`endif
      .data_out (stg_data[k+1]),
      .vld_out  (stg_vld[k+1])
    );
  end

  assign bus.q         = stg_data[DEPTH];
  assign bus.out_valid = stg_vld[DEPTH];

endmodule

// File: tb/tb_reg_bank_pipe.sv
// tb/tb_reg_bank_pipe.sv - self-checking bench for reg_bank_pipe
// Config macro: REG_BANK_PARITY_EN also checks q_par.
module tb_reg_bank_pipe;

  localparam int NUM_CH = 3;
  localparam int WIDTH  = 8;
  localparam int DEPTH  = 2;
  localparam int NW     = NUM_CH * WIDTH;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  reg_bank_pipe_if #(.NUM_CH(NUM_CH), .WIDTH(WIDTH)) bus ();

  reg_bank_pipe #(
    .NUM_CH (NUM_CH),
    .WIDTH  (WIDTH),
    .DEPTH  (DEPTH)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: a list of the words accepted on each enabled edge, newest first.
  // The output is the entry accepted DEPTH enabled edges ago.
  typedef struct {
    logic          v;
    logic [NW-1:0] w;
  } ent_t;
  ent_t hist[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_edge();
    ent_t e;
    if (!rst_n) begin
      hist.delete();
      for (int k = 0; k < DEPTH; k++) hist.push_back('{v: 1'b0, w: '0});
    end else if (bus.flush) begin
      foreach (hist[k]) hist[k].v = 1'b0;
    end else if (bus.enable) begin
      e.v = bus.in_valid;
      e.w = hist[0].w;
      for (int i = 0; i < NUM_CH; i++)
        if (bus.in_valid && bus.ch_en[i]) e.w[i*WIDTH +: WIDTH] = bus.d[i*WIDTH +: WIDTH];
      hist.push_front(e);
      void'(hist.pop_back());
    end
  endtask

  function automatic logic [NUM_CH-1:0] par_of(input logic [NW-1:0] w);
    logic [NUM_CH-1:0] p;
    for (int i = 0; i < NUM_CH; i++) p[i] = ^w[i*WIDTH +: WIDTH];
    return p;
  endfunction

  // Apply inputs, take one edge, then compare DUT against the model.
  task automatic cyc(input logic rn, input logic en, input logic fl, input logic iv,
                     input logic [NUM_CH-1:0] ce, input logic [NW-1:0] dd);
    rst_n        = rn;
    bus.enable   = en;
    bus.flush    = fl;
    bus.in_valid = iv;
    bus.ch_en    = ce;
    bus.d        = dd;
    @(posedge clk);
    model_edge();
    #1;
    check("q", 64'(bus.q), 64'(hist[DEPTH-1].w));
    check("out_valid", 64'(bus.out_valid), 64'(hist[DEPTH-1].v));
`ifdef REG_BANK_PARITY_EN
    check("q_par", 64'(bus.q_par), 64'(par_of(hist[DEPTH-1].w)));
`endif
  endtask

  initial begin
    total = 0;
    bad   = 0;
    for (int k = 0; k < DEPTH; k++) hist.push_back('{v: 1'b0, w: '0});

    // Reset held for two edges with live-looking inputs.
    cyc(0, 1, 0, 1, 3'b111, 24'hF00F01);
    check("rst_q", 64'(bus.q), 64'h0);
    check("rst_ov", 64'(bus.out_valid), 64'h0);
    cyc(0, 1, 0, 1, 3'b111, 24'hF00F01);
    check("rst_q2", 64'(bus.q), 64'h0);
    check("rst_ov2", 64'(bus.out_valid), 64'h0);

    // Flow: two words back to back; first emerges after two edges.
    cyc(1, 1, 0, 1, 3'b111, 24'hF0FF01);
    check("flow_ov1", 64'(bus.out_valid), 64'h0);
    cyc(1, 1, 0, 1, 3'b111, 24'hF0AA01);
    check("flow_q", 64'(bus.q), 64'hF0FF01);
    check("flow_ov", 64'(bus.out_valid), 64'h1);

    // Stall three cycles while d changes.
    for (int s = 0; s < 3; s++) begin
      cyc(1, 0, 0, 1, 3'b111, 24'h000000);
      check("stall_q", 64'(bus.q), 64'hF0FF01);
      check("stall_ov", 64'(bus.out_valid), 64'h1);
    end
    cyc(1, 1, 0, 0, 3'b111, 24'h000000);
    check("resume_q", 64'(bus.q), 64'hF0AA01);
    check("resume_ov", 64'(bus.out_valid), 64'h1);
    cyc(1, 1, 0, 0, 3'b111, 24'h000000);
    check("bubble_ov", 64'(bus.out_valid), 64'h0);
    check("bubble_q", 64'(bus.q), 64'hF0AA01);

    // Mask: only lane 1 loads.
    cyc(1, 1, 0, 1, 3'b010, 24'h112233);
    cyc(1, 1, 0, 0, 3'b111, 24'h000000);
    check("mask_q", 64'(bus.q), 64'hF02201);
    check("mask_ov", 64'(bus.out_valid), 64'h1);

    // Flush wins over enable; data stays.
    cyc(1, 1, 0, 1, 3'b111, 24'h123456);
    cyc(1, 1, 1, 1, 3'b111, 24'h654321);
    check("flush_ov1", 64'(bus.out_valid), 64'h0);
    check("flush_q1", 64'(bus.q), 64'hF02201);
    cyc(1, 1, 1, 1, 3'b111, 24'h654321);
    check("flush_ov2", 64'(bus.out_valid), 64'h0);
    check("flush_q2", 64'(bus.q), 64'hF02201);

    // All lanes masked with in_valid: previous word re-issued as valid.
    cyc(1, 1, 0, 1, 3'b000, 24'hABCDEF);
    cyc(1, 1, 0, 0, 3'b000, 24'h000000);
    check("reissue_q", 64'(bus.q), 64'h123456);
    check("reissue_ov", 64'(bus.out_valid), 64'h1);

`ifdef REG_BANK_PARITY_EN
    cyc(1, 1, 0, 1, 3'b111, 24'h070301);
    cyc(1, 1, 0, 0, 3'b111, 24'h000000);
    check("par_lit", 64'(bus.q_par), 64'h5);
`endif

    // Randomised traffic including mid-stream resets and flushes.
    for (int n = 0; n < 600; n++) begin
      cyc(($urandom_range(0, 49) != 0),
          ($urandom_range(0, 9) < 7),
          ($urandom_range(0, 19) == 0),
          ($urandom_range(0, 3) != 0),
          NUM_CH'($urandom_range(0, 7)),
          NW'($urandom));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
